// File: rtl/rf_pkg.sv
// Shared constants and types for the register-bank operand-fetch stage.
`timescale 1ns/1ps
package rf_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 2 ** AW;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, set has priority.
`timescale 1ns/1ps
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            setEn,
  input  reg_addr_t       setAddr,
  input  logic            clrEn,
  input  reg_addr_t       clrAddr,
  input  reg_addr_t       lookAddr1,
  input  reg_addr_t       lookAddr2,
  input  reg_addr_t       lookAddr3,
  output logic [NREG-1:0] busy,
  output logic            look1,
  output logic            look2,
  output logic            look3
);

  logic [NREG-1:0] busyQ, busyD;

  // Clear first so a same-cycle set on the same register survives.
  always_comb begin
    busyD = busyQ;
    if (clrEn) busyD[clrAddr] = 1'b0;
    if (setEn) busyD[setAddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busyQ <= '0;
    end else begin
      busyQ <= busyD;
    end
  end

  assign busy  = busyQ;
  assign look1 = busyQ[lookAddr1];
  assign look2 = busyQ[lookAddr2];
  assign look3 = busyQ[lookAddr3];

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage: reads the bank, bypasses writeback, stalls on RAW/WAW
// hazards and owns the bank write port.
`timescale 1ns/1ps
module regfile_operand_fetch
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  reg_addr_t       iss_sr1,
  input  reg_addr_t       iss_sr2,
  input  reg_addr_t       iss_dr,
  output logic            op_valid,
  input  logic            op_ready,
  output reg_data_t       op_a,
  output reg_data_t       op_b,
  output reg_addr_t       op_dr,
  input  logic            wb_valid,
  input  reg_addr_t       wb_dr,
  input  reg_data_t       wb_data,
  output reg_addr_t       rf_sr1,
  output reg_addr_t       rf_sr2,
  output reg_addr_t       rf_dr,
  output reg_data_t       rf_wrData,
  output logic            rf_wr,
  input  reg_data_t       rf_rdData1,
  input  reg_data_t       rf_rdData2,
  output logic [NREG-1:0] busy_o,
  output logic            wb_err
);

  logic      opValidQ;
  reg_data_t opAQ, opBQ;
  reg_addr_t opDrQ;
  logic      wbErrQ;

  logic      busy1, busy2, busyD;
  logic      hit1, hit2, hitD;
  logic      raw1, raw2, waw;
  logic      accept;
  logic      wbSpurious;

  assign rf_sr1    = iss_sr1;
  assign rf_sr2    = iss_sr2;
  assign rf_dr     = wb_dr;
  assign rf_wrData = wb_data;
  assign rf_wr     = wb_valid & rst;

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .setEn     (accept),
    .setAddr   (iss_dr),
    .clrEn     (wb_valid),
    .clrAddr   (wb_dr),
    .lookAddr1 (iss_sr1),
    .lookAddr2 (iss_sr2),
    .lookAddr3 (iss_dr),
    .busy      (busy_o),
    .look1     (busy1),
    .look2     (busy2),
    .look3     (busyD)
  );

  // A writeback landing this edge resolves the hazard it would otherwise cause.
  assign hit1 = wb_valid && (wb_dr == iss_sr1);
  assign hit2 = wb_valid && (wb_dr == iss_sr2);
  assign hitD = wb_valid && (wb_dr == iss_dr);
  assign raw1 = busy1 && !hit1;
  assign raw2 = busy2 && !hit2;
  assign waw  = busyD && !hitD;

  assign iss_ready  = (!opValidQ || op_ready) && !raw1 && !raw2 && !waw;
  assign accept     = iss_valid && iss_ready;
  assign wbSpurious = wb_valid && !busy_o[wb_dr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opValidQ <= 1'b0;
      opAQ     <= '0;
      opBQ     <= '0;
      opDrQ    <= '0;
      wbErrQ   <= 1'b0;
    end else begin
      if (accept) begin
        opValidQ <= 1'b1;
        opAQ     <= hit1 ? wb_data : rf_rdData1;
        opBQ     <= hit2 ? wb_data : rf_rdData2;
        opDrQ    <= iss_dr;
      end else if (op_ready) begin
        opValidQ <= 1'b0;
      end
      if (wbSpurious) wbErrQ <= 1'b1;
    end
  end

  assign op_valid = opValidQ;
  assign op_a     = opAQ;
  assign op_b     = opBQ;
  assign op_dr    = opDrQ;
  assign wb_err   = wbErrQ;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Scoreboard bench: directed issues push expected bundles, a monitor pops on handshake.
`timescale 1ns/1ps
module tb_regfile_operand_fetch;
  import rf_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid, iss_ready;
  reg_addr_t       iss_sr1, iss_sr2, iss_dr;
  logic            op_valid, op_ready;
  reg_data_t       op_a, op_b;
  reg_addr_t       op_dr;
  logic            wb_valid;
  reg_addr_t       wb_dr;
  reg_data_t       wb_data;
  reg_addr_t       rf_sr1, rf_sr2, rf_dr;
  reg_data_t       rf_wrData, rf_rdData1, rf_rdData2;
  logic            rf_wr;
  logic [NREG-1:0] busy_o;
  logic            wb_err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dr;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] bank[NREG];

  always #5 clk = ~clk;

  regfile_operand_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_sr1    (iss_sr1),
    .iss_sr2    (iss_sr2),
    .iss_dr     (iss_dr),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_dr      (op_dr),
    .wb_valid   (wb_valid),
    .wb_dr      (wb_dr),
    .wb_data    (wb_data),
    .rf_sr1     (rf_sr1),
    .rf_sr2     (rf_sr2),
    .rf_dr      (rf_dr),
    .rf_wrData  (rf_wrData),
    .rf_wr      (rf_wr),
    .rf_rdData1 (rf_rdData1),
    .rf_rdData2 (rf_rdData2),
    .busy_o     (busy_o),
    .wb_err     (wb_err)
  );

  // Behavioural register bank: combinational read, clocked write, not reset.
  always @(posedge clk) if (rf_wr) bank[rf_dr] <= rf_wrData;
  assign rf_rdData1 = bank[rf_sr1];
  assign rf_rdData2 = bank[rf_sr2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] dr);
    exp_t x;
    x.a  = a;
    x.b  = b;
    x.dr = dr;
    q.push_back(x);
  endtask

  task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    iss_valid = 1'b1;
    iss_sr1   = s1;
    iss_sr2   = s2;
    iss_dr    = d;
  endtask

  task automatic wb(input logic [4:0] d, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_dr    = d;
    wb_data  = data;
  endtask

  // Monitor: a bundle is consumed on any edge where op_valid && op_ready.
  always @(negedge clk) begin
    if (rst && op_valid && op_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bundle: got a=%h b=%h dr=%0d expected none", op_a, op_b, op_dr);
      end else begin
        e = q.pop_front();
        check("op_a", op_a, e.a);
        check("op_b", op_b, e.b);
        check("op_dr", {27'd0, op_dr}, {27'd0, e.dr});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; iss_valid = 1'b0; iss_sr1 = '0; iss_sr2 = '0; iss_dr = '0;
    op_ready = 1'b1; wb_valid = 1'b0; wb_dr = '0; wb_data = '0;
    step(); step();
    @(negedge clk);
    check("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_busy", busy_o, 32'd0);
    check("rst_wb_err", {31'd0, wb_err}, 32'd0);
    step();
    rst = 1'b1;

    // Leave a bundle in flight and a busy bit set, then reset mid-cycle.
    op_ready = 1'b0;
    issue(0, 0, 2);
    step();
    iss_valid = 1'b0;
    wb(4, 32'h1111);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_op_valid", {31'd0, op_valid}, 32'd0);
    check("async_busy", busy_o, 32'd0);
    check("async_rf_wr", {31'd0, rf_wr}, 32'd0);
    wb_valid = 1'b0;
    op_ready = 1'b1;
    step();
    rst = 1'b1;

    // Fill: reg k = 10*k; every write is spurious so wb_err sets.
    for (int k = 0; k < 32; k++) begin
      wb(k[4:0], 32'(10 * k));
      step();
    end
    wb_valid = 1'b0;
    @(negedge clk);
    check("fill_wb_err", {31'd0, wb_err}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("reset_clears_wb_err", {31'd0, wb_err}, 32'd0);
    step();
    rst = 1'b1;

    // Basic issue.
    issue(3, 1, 31);
    expect_op(32'd30, 32'd10, 5'd31);
    @(negedge clk);
    check("basic_ready", {31'd0, iss_ready}, 32'd1);
    step();
    iss_valid = 1'b0;
    @(negedge clk);
    check("basic_busy31", {31'd0, busy_o[31]}, 32'd1);
    step();

    // RAW stall on r5, released by a bypassed writeback.
    issue(0, 0, 5);
    expect_op(32'd0, 32'd0, 5'd5);
    step();
    issue(5, 2, 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("raw_stall_ready", {31'd0, iss_ready}, 32'd0);
      step();
    end
    wb(5, 32'hDEADBEEF);
    expect_op(32'hDEADBEEF, 32'd20, 5'd6);
    @(negedge clk);
    check("raw_release_ready", {31'd0, iss_ready}, 32'd1);
    step();
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
    @(negedge clk);
    check("raw_busy5", {31'd0, busy_o[5]}, 32'd0);
    check("raw_busy6", {31'd0, busy_o[6]}, 32'd1);
    step();

    // Backpressure: held bundle stays stable while the next issue waits.
    op_ready = 1'b0;
    issue(4, 7, 8);
    expect_op(32'd40, 32'd70, 5'd8);
    @(negedge clk);
    check("bp_first_ready", {31'd0, iss_ready}, 32'd1);
    step();
    issue(10, 11, 12);
    expect_op(32'd100, 32'd110, 5'd12);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready", {31'd0, iss_ready}, 32'd0);
      check("bp_hold_a", op_a, 32'd40);
      check("bp_hold_b", op_b, 32'd70);
      check("bp_hold_dr", {27'd0, op_dr}, 32'd8);
      step();
    end
    op_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'd0, iss_ready}, 32'd1);
    step();
    iss_valid = 1'b0;
    step();

    // Same-cycle set/clear on r7.
    issue(0, 0, 7);
    expect_op(32'd0, 32'd0, 5'd7);
    step();
    issue(1, 2, 7);
    wb(7, 32'd77);
    expect_op(32'd10, 32'd20, 5'd7);
    @(negedge clk);
    check("waw_bypass_ready", {31'd0, iss_ready}, 32'd1);
    step();
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
    @(negedge clk);
    check("setclr_busy7", {31'd0, busy_o[7]}, 32'd1);
    check("setclr_wb_err", {31'd0, wb_err}, 32'd0);
    step();

    // sr1 == sr2 with bypass from r31 (busy since the basic issue).
    issue(31, 31, 14);
    wb(31, 32'h0000CAFE);
    expect_op(32'h0000CAFE, 32'h0000CAFE, 5'd14);
    step();
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
    step();

    // Spurious writeback to non-busy r9.
    wb(9, 32'h12345678);
    step();
    wb_valid = 1'b0;
    issue(9, 9, 13);
    expect_op(32'h12345678, 32'h12345678, 5'd13);
    @(negedge clk);
    check("spurious_wb_err", {31'd0, wb_err}, 32'd1);
    step();
    iss_valid = 1'b0;
    step(); step();
    @(negedge clk);
    check("spurious_wb_err_held", {31'd0, wb_err}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("final_rst_wb_err", {31'd0, wb_err}, 32'd0);
    check("final_rst_busy", busy_o, 32'd0);
    step();
    rst = 1'b1;
    step(); step();

    check("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
